tm1638_key_reader: RTL and testbench

- Reads the TM1638 key-scan matrix. This is the read direction of the same 3-wire CLK/STB/DIO link that the display writer drives.
- On each `start` it runs one frame: STB low, command 0x42 sent LSB-first, DIO turnaround, 32 bits clocked in, STB high.
- It publishes an 8-key vector plus the 32-bit raw scan.
- It sits beside the display writer. Top-level logic grants the bus to one of them at a time; this block's `busy` gates the grant.

---
 rtl/tm1638_key_reader.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_tm1638_key_reader.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tm1638_key_reader.sv
// ---------------------------------------------------------------------------
// tm1638_key_reader
//
// Reads the TM1638 key-scan matrix over the shared 3-wire CLK/STB/DIO link.
// Each accepted `start` runs one frame:
//   STB low -> command 0x42 (LSB first) -> DIO turnaround wait ->
//   32 read bits -> STB high -> publish raw scan + decoded 8-key vector.
//
// Parameters
//   CLK_DIV  : clkinput cycles per half-period of tm_clk (>= 1)
//   WAIT_CYC : clkinput cycles with DIO released between the last command
//              bit and the first read bit (>= 1, must cover Twait >= 1 us)
//
// Ports
//   clkinput    in   block clock
//   rst         in   asynchronous reset, active high
//   start       in   one-cycle frame request, ignored unless idle
//   busy        out  high from the cycle after start until keys_valid
//   tm_clk      out  TM1638 CLK, idles high
//   tm_stb      out  TM1638 STB, idles high, active low
//   tm_dio_out  out  DIO drive value
//   tm_dio_oe   out  DIO output enable (1 = drive)
//   tm_dio_in   in   DIO pad input
//   raw_scan    out  received bits, bit i = i-th bit received
//   keys        out  decoded keys, 1 = pressed
//   keys_valid  out  one-cycle pulse when a frame completes
//   key_changed out  one-cycle pulse with keys_valid when keys changed
//
// Build option
//   TM1638_KEY_DEBOUNCE_EN : when defined, a decoded vector is committed to
//   `keys` only if it equals the vector of the previous completed frame.
// ---------------------------------------------------------------------------
module tm1638_key_reader #(
    parameter int CLK_DIV  = 4,
    parameter int WAIT_CYC = 8
) (
    input  logic        clkinput,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        tm_clk,
    output logic        tm_stb,
    output logic        tm_dio_out,
    output logic        tm_dio_oe,
    input  logic        tm_dio_in,
    output logic [31:0] raw_scan,
    output logic [7:0]  keys,
    output logic        keys_valid,
    output logic        key_changed
);

    localparam logic [7:0] CMD_READ_KEYS = 8'h42;
    localparam int         CNT_MAX       = (CLK_DIV > WAIT_CYC) ? CLK_DIV : WAIT_CYC;
    localparam int         CW            = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        STB_SETUP = 3'd1,
        CMD       = 3'd2,
        WAIT      = 3'd3,
        READ      = 3'd4,
        STB_HOLD  = 3'd5,
        DONE      = 3'd6
    } state_t;

    state_t      state, state_n;
    logic [CW-1:0] cnt, cnt_n;     // cycles spent in current phase
    logic [4:0]  bit_idx, bit_n;   // bit number within CMD (0..7) or READ (0..31)
    logic        hi, hi_n;         // 0 = low half of a bit, 1 = high half

    logic        half_last;        // last cycle of a CLK_DIV-long phase
    logic        wait_last;        // last cycle of the turnaround wait
    logic        sample_now;       // last cycle of a READ high half
    logic        commit;           // frame complete, results go out next edge

    logic [31:0] shadow;           // bits being received; raw_scan stays stable meanwhile
    logic [7:0]  keys_new;

    // Registered-output next values
    logic stb_d, clk_d, oe_d, out_d, busy_d, kv_d;

    assign half_last  = (cnt == CW'(CLK_DIV - 1));
    assign wait_last  = (cnt == CW'(WAIT_CYC - 1));
    assign sample_now = (state == READ) && hi && half_last;
    assign commit     = (state == STB_HOLD) && half_last;

    // Only bit 0 and bit 4 of each scan byte carry key state.
    function automatic logic [7:0] decode(input logic [31:0] r);
        logic [7:0] k;
        k = '0;
        for (int b = 0; b < 4; b++) begin
            k[b]     = r[8*b];
            k[b + 4] = r[8*b + 4];
        end
        return k;
    endfunction

    assign keys_new = decode(shadow);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clkinput or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            hi      <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_n;
            hi      <= hi_n;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_n = state;
        cnt_n   = cnt + CW'(1);
        bit_n   = bit_idx;
        hi_n    = hi;
        unique case (state)
            IDLE: begin
                cnt_n = '0;
                if (start) begin
                    state_n = STB_SETUP;
                end
            end
            STB_SETUP: begin
                if (half_last) begin
                    state_n = CMD;
                    cnt_n   = '0;
                    bit_n   = '0;
                    hi_n    = 1'b0;
                end
            end
            CMD: begin
                if (half_last) begin
                    cnt_n = '0;
                    if (!hi) begin
                        hi_n = 1'b1;
                    end else if (bit_idx == 5'd7) begin
                        state_n = WAIT;
                        hi_n    = 1'b0;
                    end else begin
                        bit_n = bit_idx + 5'd1;
                        hi_n  = 1'b0;
                    end
                end
            end
            WAIT: begin
                if (wait_last) begin
                    state_n = READ;
                    cnt_n   = '0;
                    bit_n   = '0;
                    hi_n    = 1'b0;
                end
            end
            READ: begin
                if (half_last) begin
                    cnt_n = '0;
                    if (!hi) begin
                        hi_n = 1'b1;
                    end else if (bit_idx == 5'd31) begin
                        state_n = STB_HOLD;
                        hi_n    = 1'b0;
                    end else begin
                        bit_n = bit_idx + 5'd1;
                        hi_n  = 1'b0;
                    end
                end
            end
            STB_HOLD: begin
                if (half_last) begin
                    state_n = DONE;
                    cnt_n   = '0;
                end
            end
            DONE: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic: decoded from the *next* state so the pins can be
    // driven straight from flops and change exactly with the state.
    // ------------------------------------------------------------------
    always_comb begin
        stb_d  = 1'b1;
        clk_d  = 1'b1;
        oe_d   = 1'b0;
        out_d  = 1'b1;
        busy_d = (state_n != IDLE);
        kv_d   = (state_n == DONE);
        unique case (state_n)
            STB_SETUP, WAIT: begin
                stb_d = 1'b0;
            end
            CMD: begin
                stb_d = 1'b0;
                clk_d = hi_n;
                oe_d  = 1'b1;
                // bit_n only advances on entry to a low half, so DIO
                // changes only on the first low cycle of each bit.
                out_d = CMD_READ_KEYS[bit_n[2:0]];
            end
            READ: begin
                stb_d = 1'b0;
                clk_d = hi_n;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clkinput or posedge rst) begin
        if (rst) begin
            tm_stb     <= 1'b1;
            tm_clk     <= 1'b1;
            tm_dio_oe  <= 1'b0;
            tm_dio_out <= 1'b1;
            busy       <= 1'b0;
            keys_valid <= 1'b0;
        end else begin
            tm_stb     <= stb_d;
            tm_clk     <= clk_d;
            tm_dio_oe  <= oe_d;
            tm_dio_out <= out_d;
            busy       <= busy_d;
            keys_valid <= kv_d;
        end
    end

    // ------------------------------------------------------------------
    // Receive shift register
    // ------------------------------------------------------------------
    always_ff @(posedge clkinput or posedge rst) begin
        if (rst) begin
            shadow <= '0;
        end else if (sample_now) begin
            shadow[bit_idx] <= tm_dio_in;
        end
    end

    // ------------------------------------------------------------------
    // Result publication (lands on the DONE cycle)
    // ------------------------------------------------------------------
`ifdef TM1638_KEY_DEBOUNCE_EN
    logic [7:0] candidate;   // decoded vector of the previous completed frame

    always_ff @(posedge clkinput or posedge rst) begin
        if (rst) begin
            raw_scan    <= '0;
            keys        <= '0;
            key_changed <= 1'b0;
            candidate   <= '0;
        end else begin
            key_changed <= 1'b0;
            if (commit) begin
                raw_scan  <= shadow;
                candidate <= keys_new;
                // Two matching frames in a row commit the vector.
                if (keys_new == candidate) begin
                    keys        <= keys_new;
                    key_changed <= (keys_new != keys);
                end
            end
        end
    end
`else
    always_ff @(posedge clkinput or posedge rst) begin
        if (rst) begin
            raw_scan    <= '0;
            keys        <= '0;
            key_changed <= 1'b0;
        end else begin
            key_changed <= 1'b0;
            if (commit) begin
                raw_scan    <= shadow;
                keys        <= keys_new;
                key_changed <= (keys_new != keys);
            end
        end
    end
`endif

endmodule

// File: tb/tb_tm1638_key_reader.sv
// ---------------------------------------------------------------------------
// Testbench for tm1638_key_reader with CLK_DIV=2, WAIT_CYC=4.
// A small TM1638 model drives DIO: after the 8 command clocks it presents
// scan bit i on the falling tm_clk edge of read bit i.
// ---------------------------------------------------------------------------
module tb_tm1638_key_reader;

    localparam int D = 2;
    localparam int W = 4;
    localparam int KV_CYC = 82 * D + W + 1;   // 169

    logic        clk;
    logic        rst;
    logic        start;
    logic        busy;
    logic        tm_clk;
    logic        tm_stb;
    logic        tm_dio_out;
    logic        tm_dio_oe;
    logic        tm_dio_in;
    logic [31:0] raw_scan;
    logic [7:0]  keys;
    logic        keys_valid;
    logic        key_changed;

    int n_checks = 0;
    int n_err    = 0;

    tm1638_key_reader #(.CLK_DIV(D), .WAIT_CYC(W)) dut (
        .clkinput    (clk),
        .rst         (rst),
        .start       (start),
        .busy        (busy),
        .tm_clk      (tm_clk),
        .tm_stb      (tm_stb),
        .tm_dio_out  (tm_dio_out),
        .tm_dio_oe   (tm_dio_oe),
        .tm_dio_in   (tm_dio_in),
        .raw_scan    (raw_scan),
        .keys        (keys),
        .keys_valid  (keys_valid),
        .key_changed (key_changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // TM1638 DIO model
    logic [31:0] scan_word = '0;
    int          fall_cnt  = 0;
    initial tm_dio_in = 1'b1;

    always @(negedge tm_clk or posedge tm_stb) begin
        if (tm_stb) begin
            fall_cnt = 0;
        end else begin
            if (fall_cnt >= 8 && fall_cnt < 40) tm_dio_in = scan_word[fall_cnt - 8];
            fall_cnt = fall_cnt + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Runs one frame and measures it. Cycle c is the c-th cycle after the
    // edge that samples start (cycle 1 = first STB_SETUP cycle).
    task automatic run_frame(
        input  logic [31:0] word,
        input  bit          extra_starts,
        output int          kv_cyc,
        output int          busy_lo,
        output int          kv_cnt,
        output logic [7:0]  cmd,
        output int          wait_n,
        output int          read_rises,
        output int          stb_viol,
        output int          raw_viol,
        output logic [31:0] raw_o,
        output logic [7:0]  keys_o,
        output logic        kc_o
    );
        logic        prev_clk, prev_stb;
        logic [31:0] raw_before;
        int          cmd_i;
        kv_cyc = -1; busy_lo = -1; kv_cnt = 0; cmd = '0; wait_n = 0;
        read_rises = 0; stb_viol = 0; raw_viol = 0; cmd_i = 0;
        raw_o = '0; keys_o = '0; kc_o = 1'b0;
        prev_clk = 1'b1; prev_stb = 1'b1;
        scan_word  = word;
        raw_before = raw_scan;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            if (c > 1) begin
                @(posedge clk); #1;
            end
            start = extra_starts && (c == 10 || c == 100);
            if (!prev_clk && tm_clk && !tm_stb) begin
                if (tm_dio_oe) begin
                    if (cmd_i < 8) cmd[cmd_i] = tm_dio_out;
                    cmd_i++;
                end else begin
                    read_rises++;
                end
            end
            if (!tm_stb && !tm_dio_oe && tm_clk && cmd_i == 8 && read_rises == 0) wait_n++;
            if (tm_stb != prev_stb && !(tm_clk && prev_clk)) stb_viol++;
            if (busy && !keys_valid && raw_scan !== raw_before) raw_viol++;
            if (keys_valid) begin
                kv_cnt++;
                if (kv_cyc < 0) begin
                    kv_cyc = c;
                    raw_o  = raw_scan;
                    keys_o = keys;
                    kc_o   = key_changed;
                end
            end
            if (!busy && busy_lo < 0 && c > 1) busy_lo = c;
            prev_clk = tm_clk;
            prev_stb = tm_stb;
        end
        start = 1'b0;
    endtask

    typedef struct {
        logic [31:0] word;
        bit          extra;
        logic [31:0] exp_raw;
        logic [7:0]  exp_keys;
        logic        exp_kc;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int          kv_cyc, busy_lo, kv_cnt, wait_n, rises, stb_viol, raw_viol, viol, kvs;
        logic [7:0]  cmd, k_o;
        logic [31:0] r_o;
        logic        kc_o;

`ifdef TM1638_KEY_DEBOUNCE_EN
        vecs[0] = '{32'h1100_1001, 1'b0, 32'h1100_1001, 8'h00, 1'b0};
        vecs[1] = '{32'h1100_1001, 1'b1, 32'h1100_1001, 8'hA9, 1'b1};
        vecs[2] = '{32'h0000_0000, 1'b0, 32'h0000_0000, 8'hA9, 1'b0};
        vecs[3] = '{32'h0000_0000, 1'b0, 32'h0000_0000, 8'h00, 1'b1};
        vecs[4] = '{32'h0000_0010, 1'b0, 32'h0000_0010, 8'h00, 1'b0};
`else
        vecs[0] = '{32'h1100_1001, 1'b0, 32'h1100_1001, 8'hA9, 1'b1};
        vecs[1] = '{32'h1100_1001, 1'b1, 32'h1100_1001, 8'hA9, 1'b0};
        vecs[2] = '{32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 8'hFF, 1'b1};
        vecs[3] = '{32'hEEEE_EEEE, 1'b0, 32'hEEEE_EEEE, 8'h00, 1'b1};
        vecs[4] = '{32'h0000_0010, 1'b0, 32'h0000_0010, 8'h10, 1'b1};
`endif

        // Reset state
        rst = 1'b1; start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_stb",  tm_stb, 1);
        chk("rst_clk",  tm_clk, 1);
        chk("rst_oe",   tm_dio_oe, 0);
        chk("rst_dout", tm_dio_out, 1);
        chk("rst_busy", busy, 0);
        chk("rst_raw",  raw_scan, 0);
        chk("rst_keys", keys, 0);
        chk("rst_kv",   keys_valid, 0);
        chk("rst_kc",   key_changed, 0);
        @(negedge clk); rst = 1'b0;

        // Idle with no start
        viol = 0;
        repeat (500) begin
            @(posedge clk); #1;
            if (!tm_stb || !tm_clk || tm_dio_oe || busy || keys != 0 || keys_valid) viol++;
        end
        chk("idle_viol", viol, 0);

        // Table-driven frames
        foreach (vecs[i]) begin
            run_frame(vecs[i].word, vecs[i].extra, kv_cyc, busy_lo, kv_cnt, cmd,
                      wait_n, rises, stb_viol, raw_viol, r_o, k_o, kc_o);
            chk($sformatf("v%0d_kv_cyc", i),  kv_cyc, KV_CYC);
            chk($sformatf("v%0d_busy_lo", i), busy_lo, KV_CYC + 1);
            chk($sformatf("v%0d_kv_cnt", i),  kv_cnt, 1);
            chk($sformatf("v%0d_cmd", i),     cmd, 8'h42);
            chk($sformatf("v%0d_wait", i),    wait_n, W);
            chk($sformatf("v%0d_rises", i),   rises, 32);
            chk($sformatf("v%0d_stb_viol", i), stb_viol, 0);
            chk($sformatf("v%0d_raw_viol", i), raw_viol, 0);
            chk($sformatf("v%0d_raw", i),     r_o, vecs[i].exp_raw);
            chk($sformatf("v%0d_keys", i),    k_o, vecs[i].exp_keys);
            chk($sformatf("v%0d_kc", i),      kc_o, vecs[i].exp_kc);
        end

        // Reset in the middle of READ
        scan_word = 32'h1100_1001;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (59) @(posedge clk);
        #1;
        chk("mid_busy_before", busy, 1);
        rst = 1'b1;
        #1;
        chk("mid_stb", tm_stb, 1);
        chk("mid_oe",  tm_dio_oe, 0);
        chk("mid_clk", tm_clk, 1);
        chk("mid_busy", busy, 0);
        @(negedge clk); rst = 1'b0;
        kvs = 0; viol = 0;
        repeat (300) begin
            @(posedge clk); #1;
            if (keys_valid) kvs++;
            if (keys != 0 || busy) viol++;
        end
        chk("mid_no_kv", kvs, 0);
        chk("mid_idle", viol, 0);

        // Normal frame after the abort
        run_frame(32'h1100_1001, 1'b0, kv_cyc, busy_lo, kv_cnt, cmd,
                  wait_n, rises, stb_viol, raw_viol, r_o, k_o, kc_o);
        chk("post_kv_cyc", kv_cyc, KV_CYC);
        chk("post_kv_cnt", kv_cnt, 1);
        chk("post_raw", r_o, 32'h1100_1001);
`ifdef TM1638_KEY_DEBOUNCE_EN
        chk("post_keys", k_o, 8'h00);
        chk("post_kc", kc_o, 0);
`else
        chk("post_keys", k_o, 8'hA9);
        chk("post_kc", kc_o, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
